// File: rtl/seq_mul_add_pkg.sv
// Shared types for the sequential multiply-accumulate unit.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Step counter must hold the value WIDTH itself, not just WIDTH-1.
  function automatic int cntBits(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/seq_mul_add_if.sv
// Operand and result handshake bundle for seq_mul_add.
interface seq_mul_add_if #(
  parameter int WIDTH = 4
);

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   q_i;
  logic [WIDTH-1:0]   b_i;
  logic [WIDTH-1:0]   r_i;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] p_o;

  modport master (
    output in_valid, q_i, b_i, r_i, out_ready,
    input  in_ready, out_valid, p_o
  );

  modport slave (
    input  in_valid, q_i, b_i, r_i, out_ready,
    output in_ready, out_valid, p_o
  );

endinterface

// File: rtl/seq_mul_add_step.sv
// One shift-add step: conditionally adds the shifted multiplicand to the accumulator.
module mul_add_step #(
  parameter int PW = 8
) (
  input  logic [PW-1:0] acc_i,
  input  logic [PW-1:0] mcand_i,
  input  logic          mplierBit_i,
  output logic [PW-1:0] acc_o
);

  // The full-width sum never carries out, since Q*B+R < 2^PW.
  assign acc_o = mplierBit_i ? (acc_i + mcand_i) : acc_i;

endmodule

// File: rtl/seq_mul_add.sv
// Radix-2 shift-add multiply-accumulate, P = Q*B + R, one operation in flight.
module seq_mul_add
  import mul_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  seq_mul_add_if.slave bus
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = cntBits(WIDTH);

  state_e          state_q, state_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [PW-1:0]   mcand_q, mcand_d;
  logic [PW-1:0]   p_q, p_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   accStep;

  mul_add_step #(
    .PW(PW)
  ) u_step (
    .acc_i      (acc_q),
    .mcand_i    (mcand_q),
    .mplierBit_i(mplier_q[0]),
    .acc_o      (accStep)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      p_q      <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      p_q      <= p_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    p_d      = p_q;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          acc_d    = {{WIDTH{1'b0}}, bus.r_i};
          mcand_d  = {{WIDTH{1'b0}}, bus.b_i};
          mplier_d = bus.q_i;
          cnt_d    = CW'(WIDTH);
          state_d  = CALC;
        end
      end
      CALC: begin
        acc_d    = accStep;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CW'(1);
        // Last step: publish the sum produced this cycle.
        if (cnt_q == CW'(1)) begin
          p_d     = accStep;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.p_o       = p_q;

endmodule

// File: tb/tb_seq_mul_add.sv
// Directed self-checking bench for seq_mul_add at WIDTH=4.
module tb_seq_mul_add;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   cycle;

  seq_mul_add_if #(.WIDTH(4)) bus ();

  seq_mul_add #(
    .WIDTH(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Waits (bounded) for in_ready, then presents operands for exactly one accept edge.
  task automatic applyStimulus(input logic [3:0] q, input logic [3:0] b,
                               input logic [3:0] r, output int acceptCycle);
    for (int i = 0; i < 50 && !bus.in_ready; i++) tick();
    if (!bus.in_ready) checkOutput("accept_timeout", 64'(bus.in_ready), 64'd1);
    bus.q_i      = q;
    bus.b_i      = b;
    bus.r_i      = r;
    bus.in_valid = 1'b1;
    tick();
    acceptCycle  = cycle;
    bus.in_valid = 1'b0;
  endtask

  task automatic waitResult(output logic [7:0] p, output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 50) begin
      tick();
      lat++;
    end
    if (!bus.out_valid) checkOutput("result_timeout", 64'(bus.out_valid), 64'd1);
    p = bus.p_o;
  endtask

  task automatic releaseResult();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  // Used with out_ready already high: accept, wait, let the handshake edge pass.
  task automatic runPipelined(input logic [3:0] q, input logic [3:0] b,
                              input logic [3:0] r, output logic [7:0] p,
                              output int acceptCycle);
    int lat;
    applyStimulus(q, b, r, acceptCycle);
    waitResult(p, lat);
    tick();
  endtask

  initial begin
    logic [7:0] p;
    logic [7:0] expP;
    logic [7:0] heldP;
    int         lat;
    int         acc0;
    int         accPrev;
    int         accNow;
    logic [3:0] vq [3];
    logic [3:0] vb [3];
    logic [3:0] vr [3];
    logic [7:0] vp [3];

    checks        = 0;
    failures      = 0;
    cycle         = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.q_i       = '0;
    bus.b_i       = '0;
    bus.r_i       = '0;

    repeat (3) tick();
    checkOutput("reset_in_ready", 64'(bus.in_ready), 64'd1);
    checkOutput("reset_out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("reset_p", 64'(bus.p_o), 64'd0);
    rst_n = 1'b1;
    tick();

    $display("[TB] max operands");
    applyStimulus(4'hF, 4'hF, 4'hF, acc0);
    waitResult(p, lat);
    checkOutput("max_p", 64'(p), 64'hF0);
    checkOutput("max_latency", 64'(lat), 64'd4);
    checkOutput("max_in_ready_busy", 64'(bus.in_ready), 64'd0);
    releaseResult();
    checkOutput("max_in_ready_after", 64'(bus.in_ready), 64'd1);
    checkOutput("max_out_valid_after", 64'(bus.out_valid), 64'd0);
    checkOutput("max_p_held", 64'(bus.p_o), 64'hF0);

    $display("[TB] zero multiplier");
    applyStimulus(4'h0, 4'hA, 4'h3, acc0);
    waitResult(p, lat);
    checkOutput("zero_q_p", 64'(p), 64'h03);
    releaseResult();

    $display("[TB] input noise during CALC");
    applyStimulus(4'h6, 4'h7, 4'h2, acc0);
    lat = 0;
    while (!bus.out_valid && lat < 50) begin
      bus.q_i      = 4'($urandom);
      bus.b_i      = 4'($urandom);
      bus.r_i      = 4'($urandom);
      bus.in_valid = 1'($urandom);
      tick();
      lat++;
    end
    bus.in_valid = 1'b0;
    checkOutput("noise_p", 64'(bus.p_o), 64'h2C);
    checkOutput("noise_latency", 64'(lat), 64'd4);
    releaseResult();

    $display("[TB] backpressure");
    applyStimulus(4'h9, 4'h9, 4'h0, acc0);
    waitResult(p, lat);
    checkOutput("bp_p", 64'(p), 64'h51);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("bp_out_valid", 64'(bus.out_valid), 64'd1);
      checkOutput("bp_p_stable", 64'(bus.p_o), 64'h51);
      checkOutput("bp_in_ready", 64'(bus.in_ready), 64'd0);
    end
    bus.out_ready = 1'b1;
    #1;
    checkOutput("bp_no_comb_path", 64'(bus.in_ready), 64'd0);
    tick();
    bus.out_ready = 1'b0;
    checkOutput("bp_in_ready_after", 64'(bus.in_ready), 64'd1);
    checkOutput("bp_out_valid_after", 64'(bus.out_valid), 64'd0);

    $display("[TB] async reset mid-CALC");
    applyStimulus(4'hF, 4'hF, 4'hF, acc0);
    tick();
    tick();
    #1 rst_n = 1'b0;
    #1;
    checkOutput("rst_in_ready", 64'(bus.in_ready), 64'd1);
    checkOutput("rst_out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("rst_p", 64'(bus.p_o), 64'd0);
    #1 rst_n = 1'b1;
    repeat (6) tick();
    checkOutput("rst_no_result", 64'(bus.out_valid), 64'd0);
    applyStimulus(4'h3, 4'h5, 4'h1, acc0);
    waitResult(p, lat);
    checkOutput("rst_next_p", 64'(p), 64'h10);
    releaseResult();

    $display("[TB] back-to-back");
    vq[0] = 4'h1; vb[0] = 4'h2; vr[0] = 4'h3; vp[0] = 8'h05;
    vq[1] = 4'hD; vb[1] = 4'hB; vr[1] = 4'h7; vp[1] = 8'h96;
    vq[2] = 4'hF; vb[2] = 4'h1; vr[2] = 4'h0; vp[2] = 8'h0F;
    bus.out_ready = 1'b1;
    accPrev = 0;
    for (int k = 0; k < 3; k++) begin
      runPipelined(vq[k], vb[k], vr[k], p, accNow);
      checkOutput($sformatf("b2b_p%0d", k), 64'(p), 64'(vp[k]));
      if (k > 0) checkOutput($sformatf("b2b_period%0d", k), 64'(accNow - accPrev), 64'd6);
      accPrev = accNow;
    end

    $display("[TB] exhaustive");
    for (int q = 0; q < 16; q++) begin
      for (int b = 0; b < 16; b++) begin
        for (int r = 0; r < 16; r++) begin
          expP = 8'(q * b + r);
          runPipelined(4'(q), 4'(b), 4'(r), p, accNow);
          checkOutput($sformatf("exh_q%0d_b%0d_r%0d", q, b, r), 64'(p), 64'(expP));
        end
      end
    end

    $display("[TB] divider round trip");
    for (int a = 0; a < 256; a++) begin
      for (int d = 1; d < 16; d++) begin
        if (a / d < 16) begin
          runPipelined(4'(a / d), 4'(d), 4'(a % d), p, accNow);
          checkOutput($sformatf("div_a%0d_b%0d", a, d), 64'(p), 64'(a));
        end
      end
    end
    bus.out_ready = 1'b0;

    heldP = bus.p_o;
    repeat (3) tick();
    checkOutput("idle_p_held", 64'(bus.p_o), 64'(heldP));
    checkOutput("idle_in_ready", 64'(bus.in_ready), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
